mem_access_ctrl: RTL and testbench

Memory-stage access controller sitting between the EX/MEM buffer, the 16-bit data memory and the MEM/WB buffer. It sequences 16-bit (narrow) and 32-bit (wide, two-word) loads and stores over the single 16-bit data-memory port, inserting configurable wait states. It freezes the upstream pipeline while an access is in flight and drives the MEM/WB buffer enable. It also assembles the 32-bit `o_MemData` word that the MEM/WB buffer captures.

---
 rtl/mem_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller.
// Sequences 16-bit and 32-bit (two-word) loads/stores over a single 16-bit
// data-memory port, with a configurable number of wait cycles per word.
// While an access is in flight the upstream pipeline is frozen, and the
// MEM/WB buffer is enabled only when the assembled result is ready.
module mem_access_ctrl #(
   parameter int AddrSize   = 16,
   parameter int WaitCycles = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_memRead,
   input  logic                i_memWrite,
   input  logic                i_wide,
   input  logic [AddrSize-1:0] i_addr,
   input  logic [31:0]         i_wdata,
   input  logic [15:0]         i_dmRdata,
   output logic [AddrSize-1:0] o_dmAddr,
   output logic [15:0]         o_dmWdata,
   output logic                o_dmRe,
   output logic                o_dmWe,
   output logic [31:0]         o_MemData,
   output logic                o_stall,
   output logic                o_wbEnable,
   output logic                o_busy
);

   // Counter must hold WaitCycles; a zero-wait build still gets one bit.
   localparam int CntW = (WaitCycles < 1) ? 1 : $clog2(WaitCycles + 1);
   localparam logic [CntW-1:0] CntLoad = CntW'(WaitCycles);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

   state_t              state_reg, state_next;
   logic [CntW-1:0]     cnt_reg, cnt_next;
   logic [AddrSize-1:0] addr_reg;
   logic [31:0]         wdata_reg;
   logic                wide_reg;
   logic                read_reg;
   logic [15:0]         word0_reg;
   logic [31:0]         memdata_reg;
   logic                req;
   logic                cnt_zero;

   assign req       = i_memRead | i_memWrite;
   assign cnt_zero  = (cnt_reg == '0);
   assign o_busy    = (state_reg != IDLE);
   assign o_MemData = memdata_reg;

   // State register and per-word wait counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Latch the request on acceptance; gather read words and publish the
   // result only on the edge that enters DONE, so an abort leaves no partial data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_reg    <= '0;
         wdata_reg   <= '0;
         wide_reg    <= 1'b0;
         read_reg    <= 1'b0;
         word0_reg   <= '0;
         memdata_reg <= '0;
      end else begin
         if (state_reg == IDLE && req) begin
            addr_reg  <= i_addr;
            wdata_reg <= i_wdata;
            wide_reg  <= i_wide;
            read_reg  <= i_memRead;   // read wins when both strobes are high
         end
         if (state_reg == ACC0 && cnt_zero && read_reg) begin
            if (wide_reg)
               word0_reg <= i_dmRdata;
            else
               memdata_reg <= {16'h0000, i_dmRdata};
         end
         if (state_reg == ACC1 && cnt_zero && read_reg)
            memdata_reg <= {word0_reg, i_dmRdata};
      end
   end

   // Next-state, memory port drive and pipeline control.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      o_dmAddr   = '0;
      o_dmWdata  = '0;
      o_dmRe     = 1'b0;
      o_dmWe     = 1'b0;
      o_stall    = 1'b0;
      o_wbEnable = 1'b0;
      case (state_reg)
         IDLE: begin
            o_stall = req;
            if (req) begin
               state_next = ACC0;
               cnt_next   = CntLoad;
            end
         end
         ACC0: begin
            o_dmAddr  = addr_reg;
            o_dmWdata = wide_reg ? wdata_reg[31:16] : wdata_reg[15:0];
            o_dmRe    = read_reg;
            o_dmWe    = ~read_reg;
            o_stall   = 1'b1;
            if (cnt_zero) begin
               state_next = wide_reg ? ACC1 : DONE;
               cnt_next   = CntLoad;
            end else begin
               cnt_next = cnt_reg - CntW'(1);
            end
         end
         ACC1: begin
            o_dmAddr  = addr_reg + AddrSize'(1);   // wraps at the top of memory
            o_dmWdata = wdata_reg[15:0];
            o_dmRe    = read_reg;
            o_dmWe    = ~read_reg;
            o_stall   = 1'b1;
            if (cnt_zero) begin
               state_next = DONE;
               cnt_next   = CntLoad;
            end else begin
               cnt_next = cnt_reg - CntW'(1);
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      o_wbEnable = ~o_stall;
      // While reset is held nothing may advance, whatever the request says.
      if (!rst) begin
         o_stall    = 1'b0;
         o_wbEnable = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: instance A runs with no wait cycles,
// instance B with two. Expected memory words and transaction results are
// queued when a request is driven and popped as the DUT produces them.
module tb_mem_access_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        mem_read, mem_write, wide, sel_b;
   logic [15:0] addr;
   logic [31:0] wdata;

   logic [15:0] a_dm_addr, a_dm_wdata, a_dm_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata;
   logic        a_re, a_we, a_stall, a_wben, a_busy;
   logic        b_re, b_we, b_stall, b_wben, b_busy;
   logic [31:0] a_md, b_md;

   logic [15:0] mem [0:65535];
   assign a_dm_rdata = mem[a_dm_addr];
   assign b_dm_rdata = mem[b_dm_addr];

   mem_access_ctrl #(.AddrSize(16), .WaitCycles(0)) dut_a (
      .clk(clk), .rst(rst),
      .i_memRead(mem_read & ~sel_b), .i_memWrite(mem_write & ~sel_b),
      .i_wide(wide), .i_addr(addr), .i_wdata(wdata), .i_dmRdata(a_dm_rdata),
      .o_dmAddr(a_dm_addr), .o_dmWdata(a_dm_wdata), .o_dmRe(a_re), .o_dmWe(a_we),
      .o_MemData(a_md), .o_stall(a_stall), .o_wbEnable(a_wben), .o_busy(a_busy)
   );

   mem_access_ctrl #(.AddrSize(16), .WaitCycles(2)) dut_b (
      .clk(clk), .rst(rst),
      .i_memRead(mem_read & sel_b), .i_memWrite(mem_write & sel_b),
      .i_wide(wide), .i_addr(addr), .i_wdata(wdata), .i_dmRdata(b_dm_rdata),
      .o_dmAddr(b_dm_addr), .o_dmWdata(b_dm_wdata), .o_dmRe(b_re), .o_dmWe(b_we),
      .o_MemData(b_md), .o_stall(b_stall), .o_wbEnable(b_wben), .o_busy(b_busy)
   );

   // Observe whichever instance is currently selected.
   logic [15:0] m_addr, m_wdata;
   logic        m_re, m_we, m_stall, m_wben, m_busy, m_strobe;
   logic [31:0] m_md;
   assign m_addr   = sel_b ? b_dm_addr  : a_dm_addr;
   assign m_wdata  = sel_b ? b_dm_wdata : a_dm_wdata;
   assign m_re     = sel_b ? b_re       : a_re;
   assign m_we     = sel_b ? b_we       : a_we;
   assign m_stall  = sel_b ? b_stall    : a_stall;
   assign m_wben   = sel_b ? b_wben     : a_wben;
   assign m_busy   = sel_b ? b_busy     : a_busy;
   assign m_md     = sel_b ? b_md       : a_md;
   assign m_strobe = m_re | m_we;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
      int          len;
   } word_t;

   typedef struct {
      int          stall;
      logic [31:0] md;
   } txn_t;

   word_t exp_words[$];
   txn_t  exp_txns[$];
   logic [31:0] exp_md_a, exp_md_b;

   int n_checks = 0;
   int n_pass   = 0;
   bit mon_en   = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Monitor state: one run per word (strobe, address, data held constant),
   // one stall run per transaction.
   int          run_len = 0;
   int          st_len  = 0;
   logic [15:0] run_addr, run_wdata;
   logic        run_we;

   task automatic close_run();
      word_t w;
      if (exp_words.size() == 0) begin
         check_val("word_unexpected", {16'h0, run_addr}, 32'hFFFF_FFFF);
      end else begin
         w = exp_words.pop_front();
         $display("word  we=%0d addr=%h data=%h len=%0d", run_we, run_addr, run_wdata, run_len);
         check_val("word_kind", {31'h0, run_we}, {31'h0, w.we});
         check_val("word_addr", {16'h0, run_addr}, {16'h0, w.addr});
         if (w.we) check_val("word_wdata", {16'h0, run_wdata}, {16'h0, w.data});
         check_val("word_len", run_len, w.len);
      end
   endtask

   task automatic close_txn();
      txn_t t;
      if (exp_txns.size() == 0) begin
         check_val("txn_unexpected", st_len, 0);
      end else begin
         t = exp_txns.pop_front();
         $display("txn   stall=%0d memdata=%h wben=%0d busy=%0d", st_len, m_md, m_wben, m_busy);
         check_val("stall_len", st_len, t.stall);
         check_val("done_wben", {31'h0, m_wben}, 32'h1);
         check_val("done_busy", {31'h0, m_busy}, 32'h1);
         check_val("memdata", m_md, t.md);
      end
   endtask

   always @(negedge clk) begin
      if (!mon_en) begin
         run_len = 0;
         st_len  = 0;
      end else begin
         if (run_len > 0 && !(m_strobe && m_addr == run_addr && m_we == run_we && m_wdata == run_wdata)) begin
            close_run();
            run_len = 0;
         end
         if (m_strobe) begin
            if (run_len == 0) begin
               run_addr  = m_addr;
               run_we    = m_we;
               run_wdata = m_wdata;
            end
            run_len++;
         end
         if (m_stall) st_len++;
         else if (st_len > 0) begin
            close_txn();
            st_len = 0;
         end
      end
   end

   // Queue the expected words/result, then present the request.
   task automatic push_access(input bit rd, input bit wr, input bit wd,
                              input logic [15:0] a, input logic [31:0] d);
      int          w;
      bit          is_wr;
      logic [15:0] a1;
      logic [31:0] md;
      word_t       wt;
      txn_t        tt;
      w     = sel_b ? 2 : 0;
      is_wr = !rd && wr;
      a1    = a + 16'd1;
      md    = sel_b ? exp_md_b : exp_md_a;
      if (rd) md = wd ? {mem[a], mem[a1]} : {16'h0000, mem[a]};
      wt.we = is_wr; wt.addr = a; wt.data = wd ? d[31:16] : d[15:0]; wt.len = 1 + w;
      exp_words.push_back(wt);
      if (wd) begin
         wt.addr = a1; wt.data = d[15:0];
         exp_words.push_back(wt);
      end
      tt.stall = wd ? 1 + 2 * (1 + w) : 1 + (1 + w);
      tt.md    = md;
      exp_txns.push_back(tt);
      if (sel_b) exp_md_b = md; else exp_md_a = md;
      mem_read = rd; mem_write = wr; wide = wd; addr = a; wdata = d;
   endtask

   // Hold the request until DONE has been seen, then step past the edge.
   task automatic wait_done();
      bit seen = 1'b0;
      for (int k = 0; k < 64 && !seen; k++) begin
         @(negedge clk);
         if (m_busy && m_wben) seen = 1'b1;
      end
      if (!seen) check_val("done_timeout", 32'h0, 32'h1);
      @(posedge clk); #2;
   endtask

   task automatic run_access(input bit rd, input bit wr, input bit wd,
                             input logic [15:0] a, input logic [31:0] d);
      push_access(rd, wr, wd, a, d);
      wait_done();
   endtask

   task automatic go_idle(input int n);
      mem_read = 1'b0; mem_write = 1'b0;
      repeat (n) begin @(posedge clk); #2; end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit          seen;
      logic [15:0] ra;
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      exp_md_a = 32'h0; exp_md_b = 32'h0;
      sel_b = 1'b0; mem_read = 1'b1; mem_write = 1'b0; wide = 1'b0;
      addr = 16'h0; wdata = 32'h0;
      rst = 1'b0;

      // Reset held with a pending load: everything quiet.
      repeat (2) @(negedge clk);
      check_val("rst_re",    {31'h0, a_re},    32'h0);
      check_val("rst_we",    {31'h0, a_we},    32'h0);
      check_val("rst_addr",  {16'h0, a_dm_addr},  32'h0);
      check_val("rst_wdata", {16'h0, a_dm_wdata}, 32'h0);
      check_val("rst_md",    a_md,             32'h0);
      check_val("rst_stall", {31'h0, a_stall}, 32'h0);
      check_val("rst_wben",  {31'h0, a_wben},  32'h0);
      check_val("rst_busy",  {31'h0, a_busy},  32'h0);
      check_val("rst_b_wben", {31'h0, b_wben}, 32'h0);

      @(posedge clk); #2;
      rst = 1'b1; mem_read = 1'b0;
      @(negedge clk);
      check_val("post_rst_wben",  {31'h0, a_wben},  32'h1);
      check_val("post_rst_stall", {31'h0, a_stall}, 32'h0);
      @(posedge clk); #2;
      mon_en = 1'b1;

      // Narrow read, no wait.
      mem[16'h0010] = 16'hBEEF;
      run_access(1'b1, 1'b0, 1'b0, 16'h0010, 32'h0);
      go_idle(1);

      // Wide write, no wait: result register must not move.
      run_access(1'b0, 1'b1, 1'b1, 16'h0020, 32'h1234_5678);
      go_idle(1);

      // Read and write together: treated as a read.
      mem[16'h0003] = 16'h0C0C;
      run_access(1'b1, 1'b1, 1'b0, 16'h0003, 32'hDEAD_BEEF);

      // Back-to-back loads: IDLE is passed through between them.
      mem[16'h0040] = 16'h4040; mem[16'h0041] = 16'h1111; mem[16'h0042] = 16'h2222;
      run_access(1'b1, 1'b0, 1'b0, 16'h0040, 32'h0);
      push_access(1'b1, 1'b0, 1'b1, 16'h0041, 32'h0);
      #1;
      check_val("b2b_idle_busy",  {31'h0, m_busy},  32'h0);
      check_val("b2b_idle_stall", {31'h0, m_stall}, 32'h1);
      wait_done();

      // Non-memory instructions pass without a bubble.
      go_idle(1);
      @(negedge clk);
      check_val("nomem_wben",  {31'h0, m_wben},  32'h1);
      check_val("nomem_stall", {31'h0, m_stall}, 32'h0);
      @(posedge clk); #2;

      // A few random accesses on the zero-wait instance.
      for (int i = 0; i < 4; i++) begin
         ra = 16'($urandom);
         mem[ra] = 16'($urandom);
         mem[16'(ra + 16'd1)] = 16'($urandom);
         if (($urandom & 1) != 0) run_access(1'b1, 1'b0, 1'($urandom), ra, 32'h0);
         else                     run_access(1'b0, 1'b1, 1'($urandom), ra, $urandom);
         go_idle(1);
      end

      // Two-wait instance: wide read across the top of memory.
      sel_b = 1'b1;
      go_idle(1);
      mem[16'hFFFF] = 16'hAAAA; mem[16'h0000] = 16'h5555;
      run_access(1'b1, 1'b0, 1'b1, 16'hFFFF, 32'h0);
      go_idle(1);

      // Abort during the second word of a wide read.
      mon_en = 1'b0;
      mem[16'h0100] = 16'h0101; mem[16'h0101] = 16'h0202;
      mem_read = 1'b1; mem_write = 1'b0; wide = 1'b1; addr = 16'h0100;
      seen = 1'b0;
      for (int k = 0; k < 32 && !seen; k++) begin
         @(negedge clk);
         if (b_re && b_dm_addr == 16'h0101) seen = 1'b1;
      end
      check_val("abort_reached_acc1", {31'h0, seen}, 32'h1);
      #2;
      rst = 1'b0;
      #1;
      $display("abort re=%0d we=%0d busy=%0d memdata=%h", b_re, b_we, b_busy, b_md);
      check_val("abort_re",    {31'h0, b_re},    32'h0);
      check_val("abort_we",    {31'h0, b_we},    32'h0);
      check_val("abort_busy",  {31'h0, b_busy},  32'h0);
      check_val("abort_md",    b_md,             32'h0);
      check_val("abort_stall", {31'h0, b_stall}, 32'h0);
      check_val("abort_wben",  {31'h0, b_wben},  32'h0);
      mem_read = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      exp_words.delete(); exp_txns.delete();
      exp_md_a = 32'h0; exp_md_b = 32'h0;
      mon_en = 1'b1;

      // Recovery: narrow read with waits after the abort.
      mem[16'h0200] = 16'h7777;
      run_access(1'b1, 1'b0, 1'b0, 16'h0200, 32'h0);
      go_idle(3);

      check_val("words_left", exp_words.size(), 32'h0);
      check_val("txns_left",  exp_txns.size(),  32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
